// File: rtl/pixel_coord_source.sv
// Raster-order pixel coordinate generator for the ray generator front end.
// Issues each (h, v) pair on two AXI-Stream channels and advances once both have accepted it.
module pixel_coord_source #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned V_ACTIVE = 768
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    output logic [10:0] hcount_axis_tdata,
    output logic        hcount_axis_tvalid,
    input  logic        hcount_axis_tready,
    output logic [9:0]  vcount_axis_tdata,
    output logic        vcount_axis_tvalid,
    input  logic        vcount_axis_tready,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned HW = 11;
    localparam int unsigned VW = 10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          h_vld_nxt;
    logic          v_vld_nxt;
    logic          h_acc;
    logic          v_acc;
    logic          h_acc_nxt;
    logic          v_acc_nxt;
    logic          busy_nxt;
    logic          done_nxt;

    logic          h_done;
    logic          v_done;
    logic          pix_done;
    logic          h_end;
    logic          last_pix;

    // A channel counts as done for the current pixel if it handshakes now or already did.
    assign h_done   = h_acc | (hcount_axis_tvalid & hcount_axis_tready);
    assign v_done   = v_acc | (vcount_axis_tvalid & vcount_axis_tready);
    assign pix_done = h_done & v_done;
    assign h_end    = (hcount_axis_tdata == HW'(H_ACTIVE - 1));
    assign last_pix = h_end && (vcount_axis_tdata == VW'(V_ACTIVE - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        h_nxt     = hcount_axis_tdata;
        v_nxt     = vcount_axis_tdata;
        h_vld_nxt = hcount_axis_tvalid;
        v_vld_nxt = vcount_axis_tvalid;
        h_acc_nxt = h_acc;
        v_acc_nxt = v_acc;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    h_nxt     = '0;
                    v_nxt     = '0;
                    h_vld_nxt = 1'b1;
                    v_vld_nxt = 1'b1;
                    h_acc_nxt = 1'b0;
                    v_acc_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (pix_done) begin
                    h_acc_nxt = 1'b0;
                    v_acc_nxt = 1'b0;
                    if (last_pix) begin
                        state_nxt = S_DONE;
                        h_vld_nxt = 1'b0;
                        v_vld_nxt = 1'b0;
                    end else begin
                        h_vld_nxt = 1'b1;
                        v_vld_nxt = 1'b1;
                        if (h_end) begin
                            h_nxt = '0;
                            v_nxt = vcount_axis_tdata + VW'(1);
                        end else begin
                            h_nxt = hcount_axis_tdata + HW'(1);
                        end
                    end
                end else begin
                    // Hold back the channel that already accepted until its partner catches up.
                    h_acc_nxt = h_done;
                    v_acc_nxt = v_done;
                    h_vld_nxt = ~h_done;
                    v_vld_nxt = ~v_done;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        busy_nxt = (state_nxt == S_RUN);
        done_nxt = (state_nxt == S_DONE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hcount_axis_tdata  <= '0;
            vcount_axis_tdata  <= '0;
            hcount_axis_tvalid <= 1'b0;
            vcount_axis_tvalid <= 1'b0;
            h_acc              <= 1'b0;
            v_acc              <= 1'b0;
            busy               <= 1'b0;
            frame_done         <= 1'b0;
        end else begin
            hcount_axis_tdata  <= h_nxt;
            vcount_axis_tdata  <= v_nxt;
            hcount_axis_tvalid <= h_vld_nxt;
            vcount_axis_tvalid <= v_vld_nxt;
            h_acc              <= h_acc_nxt;
            v_acc              <= v_acc_nxt;
            busy               <= busy_nxt;
            frame_done         <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pixel_coord_source.sv
// Bench for pixel_coord_source: randomized/directed ready patterns on a 4x3 frame
// checked against a beat-counting reference model, plus directed checks on a 1x1 frame.
module tb_pixel_coord_source;

    localparam int unsigned H = 4;
    localparam int unsigned V = 3;
    localparam int unsigned N = H * V;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        hr = 1'b0;
    logic        vr = 1'b0;
    logic [10:0] hd;
    logic        hv;
    logic [9:0]  vd;
    logic        vv;
    logic        busy;
    logic        fd;

    logic        start1 = 1'b0;
    logic        r1 = 1'b1;
    logic [10:0] hd1;
    logic        hv1;
    logic [9:0]  vd1;
    logic        vv1;
    logic        busy1;
    logic        fd1;

    pixel_coord_source #(.H_ACTIVE(H), .V_ACTIVE(V)) u_dut (
        .aclk(clk), .aresetn(aresetn), .start(start),
        .hcount_axis_tdata(hd), .hcount_axis_tvalid(hv), .hcount_axis_tready(hr),
        .vcount_axis_tdata(vd), .vcount_axis_tvalid(vv), .vcount_axis_tready(vr),
        .busy(busy), .frame_done(fd)
    );

    pixel_coord_source #(.H_ACTIVE(1), .V_ACTIVE(1)) u_dut1 (
        .aclk(clk), .aresetn(aresetn), .start(start1),
        .hcount_axis_tdata(hd1), .hcount_axis_tvalid(hv1), .hcount_axis_tready(r1),
        .vcount_axis_tdata(vd1), .vcount_axis_tvalid(vv1), .vcount_axis_tready(r1),
        .busy(busy1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: counts accepted beats per channel; pixel p is (p % H, p / H).
    int m_st = 0;   // 0 idle, 1 running, 2 done cycle
    int hc = 0;
    int vc = 0;
    int fd_seen = 0;
    int busy_seen = 0;
    int mode = 0;   // 0 both high, 1 random, 2 skewed, 3 stalled
    int cyc = 0;

    always @(negedge clk) begin
        logic exp_hv;
        logic exp_vv;
        if (!aresetn) begin
            m_st = 0;
            check("reset_outputs", {10'd0, hd, vd, hv, vv, busy, fd}, 32'd0);
        end else begin
            exp_hv = (m_st == 1) && (hc <= vc) && (hc < N);
            exp_vv = (m_st == 1) && (vc <= hc) && (vc < N);
            check("busy", 32'(busy), 32'(m_st == 1));
            check("frame_done", 32'(fd), 32'(m_st == 2));
            check("h_tvalid", 32'(hv), 32'(exp_hv));
            check("v_tvalid", 32'(vv), 32'(exp_vv));
            if (exp_hv) check("h_tdata", 32'(hd), 32'(hc % H));
            if (exp_vv) check("v_tdata", 32'(vd), 32'(vc / H));
            if (fd) fd_seen++;
            if (busy) busy_seen++;
            case (m_st)
                0: if (start) begin m_st = 1; hc = 0; vc = 0; end
                1: begin
                    if (exp_hv && hr) hc++;
                    if (exp_vv && vr) vc++;
                    if (hc == N && vc == N) m_st = 2;
                end
                default: m_st = 0;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        case (mode)
            0: begin hr = 1'b1; vr = 1'b1; end
            1: begin hr = 1'($urandom_range(0, 1)); vr = 1'($urandom_range(0, 1)); end
            2: begin hr = 1'b1; vr = ((cyc % 3) == 0); end
            default: begin hr = 1'b0; vr = 1'b0; end
        endcase
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (m_st != 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (m_st != 0) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_pixel(input string tag, input int p, input int budget);
        int k = 0;
        while (!(hc == p && vc == p) && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (!(hc == p && vc == p)) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
        repeat (2) @(posedge clk);

        // Full-rate frame
        mode = 0; fd_seen = 0; busy_seen = 0;
        pulse_start();
        wait_idle("full_rate_timeout", 100);
        check("full_rate_busy_cycles", 32'(busy_seen), 32'd12);
        check("full_rate_done_count", 32'(fd_seen), 32'd1);

        // Skewed acceptance
        mode = 2; fd_seen = 0;
        pulse_start();
        wait_idle("skew_timeout", 500);
        check("skew_done_count", 32'(fd_seen), 32'd1);
        check("skew_h_beats", 32'(hc), 32'(N));
        check("skew_v_beats", 32'(vc), 32'(N));

        // Full stall at (2,1)
        mode = 0;
        pulse_start();
        wait_pixel("stall_reach_timeout", 6, 100);
        mode = 3;
        repeat (20) @(negedge clk);
        check("stall_h_data", 32'(hd), 32'd2);
        check("stall_v_data", 32'(vd), 32'd1);
        check("stall_valids", {30'd0, hv, vv}, 32'd3);
        mode = 0;
        @(negedge clk); @(negedge clk);
        check("resume_h_data", 32'(hd), 32'd3);
        check("resume_v_data", 32'(vd), 32'd1);
        wait_idle("stall_timeout", 100);

        // Start while busy is ignored
        fd_seen = 0; busy_seen = 0;
        pulse_start();
        wait_pixel("busy_start_reach_timeout", 5, 100);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle("busy_start_timeout", 100);
        repeat (4) @(negedge clk);
        check("busy_start_done_count", 32'(fd_seen), 32'd1);
        check("busy_start_busy_cycles", 32'(busy_seen), 32'd12);

        // Asynchronous reset mid-frame at (3,1)
        fd_seen = 0;
        pulse_start();
        wait_pixel("reset_reach_timeout", 7, 100);
        @(posedge clk); #3;
        aresetn = 1'b0;
        #1;
        check("async_reset_outputs", {10'd0, hd, vd, hv, vv, busy, fd}, 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 aresetn = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_no_done", 32'(fd_seen), 32'd0);
        pulse_start();
        @(negedge clk);
        check("restart_h_data", 32'(hd), 32'd0);
        check("restart_v_data", 32'(vd), 32'd0);
        wait_idle("restart_timeout", 100);

        // Randomized readys over several frames
        mode = 1;
        for (int f = 0; f < 6; f++) begin
            fd_seen = 0;
            pulse_start();
            wait_idle("random_timeout", 2000);
            repeat (2) @(negedge clk);
            check("random_done_count", 32'(fd_seen), 32'd1);
        end
        mode = 0;

        // Degenerate 1x1 frame with back-to-back start
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        @(negedge clk);
        check("one_beat", {24'd0, 1'b0, hv1, vv1, busy1, fd1, 3'd0}, {24'd0, 8'b0111_0000});
        check("one_data", {11'd0, hd1, vd1}, 32'd0);
        @(posedge clk); #1 start1 = 1'b1;
        @(negedge clk);
        check("one_done", {28'd0, hv1, vv1, busy1, fd1}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("one_done_start_ignored", {28'd0, hv1, vv1, busy1, fd1}, 32'd0);
        @(posedge clk); #1 start1 = 1'b0;
        @(negedge clk);
        check("one_back_to_back", {28'd0, hv1, vv1, busy1, fd1}, 32'd14);
        @(negedge clk);
        check("one_back_to_back_done", {28'd0, hv1, vv1, busy1, fd1}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
